// File: rtl/fetch_fifo_multi.sv
// fetch_fifo_multi: splits 4/8-byte fetch words into 32-bit instruction entries, with offset skip and taken-branch truncation
module fetch_fifo_multi #(
  parameter int FETCH_BYTES = 8,
  parameter int DEPTH = 8,
  parameter int BP_W = 8,
  localparam int SLOTS = FETCH_BYTES / 4,
  localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [63:0]       in_addr_i,
  input  logic [8*FETCH_BYTES-1:0] in_rdata_i,
  input  logic              in_bp_valid_i,
  input  logic              in_bp_taken_i,
  input  logic [SW-1:0]     in_bp_slot_i,
  input  logic [BP_W-1:0]   in_bp_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [63:0]       out_addr_o,
  output logic [31:0]       out_instr_o,
  output logic              out_bp_valid_o,
  output logic [BP_W-1:0]   out_bp_o,
  output logic [AW:0]       count_o
);
  logic [63:0] addr_q [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic bpv_q [DEPTH];
  logic [BP_W-1:0] bp_q [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [SW-1:0] f, slot, l;
  logic [SW:0] n;
  logic used, push, pop;
  // masking with SLOTS-1 collapses the slot fields to 0 in the 4-byte configuration
  always_comb begin
    f = in_addr_i[SW+1:2] & SW'(SLOTS - 1);
    slot = in_bp_slot_i & SW'(SLOTS - 1);
    used = in_bp_valid_i && slot >= f;
    l = (used && in_bp_taken_i) ? slot : SW'(SLOTS - 1);
    n = {1'b0, l} - {1'b0, f} + (SW+1)'(1);
    in_ready_o = count_o <= (AW+1)'(DEPTH - SLOTS) && !flush_i;
    out_valid_o = count_o != '0 && !flush_i;
    push = in_valid_i && in_ready_o;
    pop = out_valid_o && out_ready_i;
    out_addr_o = addr_q[rptr];
    out_instr_o = instr_q[rptr];
    out_bp_valid_o = out_valid_o && bpv_q[rptr];
    out_bp_o = out_bp_valid_o ? bp_q[rptr] : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      count_o <= '0;
      rptr <= '0;
      wptr <= '0;
    end else begin
      if (push) begin
        for (int s = 0; s < SLOTS; s++)
          if (s >= int'(f) && s <= int'(l)) begin
            addr_q[wptr + AW'(s) - AW'(f)] <= (in_addr_i & ~64'(FETCH_BYTES - 1)) | 64'(s * 4);
            instr_q[wptr + AW'(s) - AW'(f)] <= in_rdata_i[32*s +: 32];
            bpv_q[wptr + AW'(s) - AW'(f)] <= used && s == int'(slot);
            bp_q[wptr + AW'(s) - AW'(f)] <= (used && s == int'(slot)) ? in_bp_i : '0;
          end
        wptr <= wptr + AW'(n);
      end
      if (pop) rptr <= rptr + AW'(1);
      count_o <= count_o + (push ? (AW+1)'(n) : '0) - (AW+1)'(pop);
    end
  end
endmodule
